// File: rtl/framebuffer_fetch_arbiter_if.sv
// ---------------------------------------------------------------------------
// framebuffer_fetch_arbiter_if
//
// Purpose:
//   Bundles the two bus-like channels of the framebuffer fetch arbiter.
//   - The host write channel is a valid/ready handshake.
//   - The single-port framebuffer RAM channel carries address, read and write
//     strobes, and write data. Read data comes back one cycle after mem_re.
//
// Signals:
//   host_valid  host write request
//   host_ready  write accepted this cycle when host_valid & host_ready
//   host_addr   host write address (ADDR_W)
//   host_wdata  host write data (DATA_W)
//   mem_addr    RAM address (ADDR_W)
//   mem_re      RAM read strobe
//   mem_we      RAM write strobe
//   mem_wdata   RAM write data (DATA_W)
//   mem_rdata   RAM read data, valid one cycle after mem_re (DATA_W)
//
// Modports:
//   master  the environment side: host requester plus RAM model
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface framebuffer_fetch_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
) ();

   logic              host_valid;
   logic              host_ready;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output host_valid,
      output host_addr,
      output host_wdata,
      output mem_rdata,
      input  host_ready,
      input  mem_addr,
      input  mem_re,
      input  mem_we,
      input  mem_wdata
   );

   modport slave (
      input  host_valid,
      input  host_addr,
      input  host_wdata,
      input  mem_rdata,
      output host_ready,
      output mem_addr,
      output mem_re,
      output mem_we,
      output mem_wdata
   );

endinterface

// File: rtl/framebuffer_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// framebuffer_fetch_arbiter
//
// Purpose:
//   Shares one single-port framebuffer RAM between the video line fetcher and
//   a host write port. Every newline with fetch_en set starts a prefetch of the
//   requested framebuffer row into one bank of a ping-pong line buffer, while
//   the pixel pipeline displays the other bank. The host owns the RAM whenever
//   no fetch is running, and also gets one guaranteed slot every
//   HOST_SLOT_PERIOD cycles during a fetch so it can never be starved.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   newline           one-cycle pulse at line start
//   fetch_en          sampled with newline: the next line must be fetched
//   fetch_y           framebuffer row to fetch, sampled with newline
//   bus               host write channel + RAM channel (slave modport)
//   lb_we             line buffer write strobe
//   lb_addr           line buffer pixel index
//   lb_wdata          line buffer write data
//   lb_bank           bank being filled; the display reads !lb_bank
//   fetch_busy        high while a fetch (including its final return) runs
//
// Optional feature (macro FETCH_UNDERRUN_DETECT_EN):
//   underrun          sticky flag, set when a newline arrives mid-fetch
//   underrun_count    number of such events, saturating at 255
//   When the macro is undefined the ports and logic are absent; the
//   abort/restart behaviour on a mid-fetch newline is the same either way.
// ---------------------------------------------------------------------------
module framebuffer_fetch_arbiter #(
   parameter int H_PIXELS         = 256,
   parameter int ADDR_W           = 17,
   parameter int DATA_W           = 8,
   parameter int HOST_SLOT_PERIOD = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        newline,
   input  logic                        fetch_en,
   input  logic [8:0]                  fetch_y,
   framebuffer_fetch_arbiter_if.slave  bus,
   output logic                        lb_we,
   output logic [$clog2(H_PIXELS)-1:0] lb_addr,
   output logic [DATA_W-1:0]           lb_wdata,
   output logic                        lb_bank,
   output logic                        fetch_busy
`ifdef FETCH_UNDERRUN_DETECT_EN
   ,
   output logic                        underrun,
   output logic [7:0]                  underrun_count
`endif
);

   localparam int X_W    = $clog2(H_PIXELS);
   localparam int SLOT_W = $clog2(HOST_SLOT_PERIOD);

   localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(HOST_SLOT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [8:0]        fetch_y_q;
   logic [X_W-1:0]    fetch_x_q;
   logic [SLOT_W-1:0] slot_q;
   logic              lb_bank_q;

   // Read-return pipeline: one stage, lined up with the RAM's one-cycle latency
   logic              rd_pend_q;
   logic [X_W-1:0]    rd_x_q;

   // Per-cycle decisions from the next-state logic
   logic start_fetch;
   logic host_take;
   logic rd_issue;
   logic overrun;

   // Next-state and RAM-port steering.
   // A newline seen during FETCH or DRAIN aborts the current line: that cycle
   // issues no access and either restarts on the new row or drops back to IDLE.
   // All strobes are forced low while reset is asserted so nothing leaks out
   // during the reset cycle itself.
   always_comb begin
      state_d        = state_q;
      start_fetch    = 1'b0;
      host_take      = 1'b0;
      rd_issue       = 1'b0;
      bus.host_ready = 1'b0;
      bus.mem_re     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;

      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (newline && fetch_en) begin
                  state_d     = FETCH;
                  start_fetch = 1'b1;
               end else begin
                  host_take = bus.host_valid;
               end
            end
            FETCH: begin
               if (newline) begin
                  state_d     = fetch_en ? FETCH : IDLE;
                  start_fetch = fetch_en;
               end else if (slot_q == SLOT_LAST && bus.host_valid) begin
                  host_take = 1'b1;
               end else begin
                  rd_issue = 1'b1;
                  if (fetch_x_q == X_LAST) begin
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (newline) begin
                  state_d     = fetch_en ? FETCH : IDLE;
                  start_fetch = fetch_en;
               end else begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (host_take) begin
         bus.host_ready = 1'b1;
         bus.mem_we     = 1'b1;
         bus.mem_addr   = bus.host_addr;
         bus.mem_wdata  = bus.host_wdata;
      end

      if (rd_issue) begin
         bus.mem_re   = 1'b1;
         bus.mem_addr = ADDR_W'({fetch_y_q, fetch_x_q});
      end
   end

   assign overrun = newline && (state_q != IDLE);

   // State register plus fetch bookkeeping.
   // Starting a fetch latches the row, rewinds the pixel index and slot
   // counter, and flips the bank so the finished line becomes displayable.
   // The slot counter free-runs through every FETCH cycle, whether or not the
   // host actually uses its slot. fetch_x only advances on issued reads and
   // rewinds when the last pixel goes out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         fetch_y_q <= '0;
         fetch_x_q <= '0;
         slot_q    <= '0;
         lb_bank_q <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_x_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_issue;
         rd_x_q    <= rd_issue ? fetch_x_q : '0;

         if (start_fetch) begin
            fetch_y_q <= fetch_y;
            fetch_x_q <= '0;
            slot_q    <= '0;
            lb_bank_q <= ~lb_bank_q;
         end else if (state_q == FETCH) begin
            slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            if (rd_issue) begin
               fetch_x_q <= (fetch_x_q == X_LAST) ? '0 : fetch_x_q + 1'b1;
            end
         end
      end
   end

`ifdef FETCH_UNDERRUN_DETECT_EN
   // Underrun tracking: the flag is sticky until reset and the counter
   // saturates instead of wrapping, so a long-running overrun stays visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else if (overrun) begin
         underrun <= 1'b1;
         if (underrun_count != 8'hFF) begin
            underrun_count <= underrun_count + 8'd1;
         end
      end
   end
`else
   logic unused_overrun;
   assign unused_overrun = overrun;
`endif

   // The pending read return is dropped if reset lands on the cycle it would
   // have been written, so no stray line-buffer write follows a reset.
   assign lb_we      = rd_pend_q && !reset;
   assign lb_addr    = rd_x_q;
   assign lb_wdata   = (rd_pend_q && !reset) ? bus.mem_rdata : '0;
   assign lb_bank    = lb_bank_q;
   assign fetch_busy = (state_q != IDLE);

endmodule
